// File: rtl/ms_pipe_cluster_pkg.sv
// Shared opcode encoding and saturation detection for the multiply/shift cluster.
package ms_pipe_cluster_pkg;

  typedef enum logic [2:0] {
    OP_MULU     = 3'd0,
    OP_MULS     = 3'd1,
    OP_MULU_SAT = 3'd2,
    OP_MULS_SAT = 3'd3,
    OP_SLL      = 3'd4,
    OP_SRL      = 3'd5,
    OP_SRA      = 3'd6,
    OP_ROL      = 3'd7
  } ms_op_t;

  localparam int unsigned MS_OP_SHIFT_BIT = 2;
  localparam int unsigned MS_PROD_W       = 128;

  // prod holds a 2*w-bit product zero-extended to MS_PROD_W bits.
  function automatic logic sat_u_ovf(input logic [MS_PROD_W-1:0] prod, input int unsigned w);
    return (prod >> w) != '0;
  endfunction

  // Signed product fits in w bits only if bits [2w-1:w-1] are all equal.
  function automatic logic sat_s_ovf(input logic [MS_PROD_W-1:0] prod, input int unsigned w);
    logic [MS_PROD_W-1:0] mask;
    logic [MS_PROD_W-1:0] hi;
    mask = (MS_PROD_W'(1) << (w + 1)) - MS_PROD_W'(1);
    hi   = (prod >> (w - 1)) & mask;
    return (hi != '0) && (hi != mask);
  endfunction

endpackage

// File: rtl/ms_pipe_cluster_out_fifo.sv
// Output result buffer: circular FIFO with occupancy count; head zeroed when empty.
module ms_out_fifo #(
  parameter int unsigned DW    = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           din,
  input  logic                    pop,
  output logic [DW-1:0]           dout,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign valid = (cnt != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt == FULL_CNT));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && cnt == '0));

endmodule

// File: rtl/ms_pipe_cluster.sv
// Pipelined multiply / barrel-shift ALU slot with credit-checked output buffer.
module ms_pipe_cluster
  import ms_pipe_cluster_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_STAGES = 3,
  parameter int unsigned OBUF_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Active,
  input  logic             I_Valid,
  input  logic [2:0]       I_Opcode,
  input  logic             I_Rls,
  input  logic [WIDTH-1:0] I_OperandA,
  input  logic [WIDTH-1:0] I_OperandB,
  output logic             O_Nack,
  output logic             O_Valid,
  output logic [WIDTH-1:0] O_Result,
  output logic             O_Sat,
  output logic             O_Rls,
  input  logic             I_Nack
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned NREG = MULT_STAGES - 1;
  localparam int unsigned CW   = $clog2(OBUF_DEPTH) + 1;

  typedef struct packed {
    logic               valid;
    ms_op_t             op;
    logic               rls;
    logic [2*WIDTH-1:0] data;
  } stage_t;

  stage_t           s_in;
  stage_t           s_last;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_valid;
  logic [CW-1:0]    fifo_cnt;
  int unsigned      inflight;
  logic [WIDTH-1:0] res_last;
  logic             sat_last;
  logic [WIDTH+1:0] fifo_din;
  logic [WIDTH+1:0] fifo_dout;

  assign O_Nack = ~I_Active | ((32'(fifo_cnt) + inflight) >= OBUF_DEPTH);
  assign accept = I_Valid & I_Active & ~O_Nack;

  // Stage 1: full product or shift result, carried in one 2*WIDTH field.
  always_comb begin
    logic [SHW-1:0]   amt;
    logic [SHW:0]     rol_back;
    logic [WIDTH-1:0] sra_res;
    amt      = I_OperandB[SHW-1:0];
    rol_back = (SHW + 1)'(WIDTH) - (SHW + 1)'(amt);
    sra_res  = $signed(I_OperandA) >>> amt;
    s_in       = '0;
    s_in.valid = accept;
    s_in.op    = ms_op_t'(I_Opcode);
    s_in.rls   = I_Rls;
    case (s_in.op)
      OP_MULU, OP_MULU_SAT:
        s_in.data = {{WIDTH{1'b0}}, I_OperandA} * {{WIDTH{1'b0}}, I_OperandB};
      OP_MULS, OP_MULS_SAT:
        s_in.data = {{WIDTH{I_OperandA[WIDTH-1]}}, I_OperandA}
                  * {{WIDTH{I_OperandB[WIDTH-1]}}, I_OperandB};
      OP_SLL:  s_in.data = {{WIDTH{1'b0}}, I_OperandA << amt};
      OP_SRL:  s_in.data = {{WIDTH{1'b0}}, I_OperandA >> amt};
      OP_SRA:  s_in.data = {{WIDTH{1'b0}}, sra_res};
      OP_ROL:  s_in.data = {{WIDTH{1'b0}}, (I_OperandA << amt) | (I_OperandA >> rol_back)};
      default: s_in.data = '0;
    endcase
  end

  if (NREG == 0) begin : g_direct
    assign s_last   = s_in;
    assign inflight = 0;
  end else begin : g_pipe
    stage_t s_q [NREG];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned i = 0; i < NREG; i++) s_q[i] <= '0;
      end else if (I_Active) begin
        s_q[0] <= s_in;
        for (int unsigned i = 1; i < NREG; i++) s_q[i] <= s_q[i-1];
      end
    end

    always_comb begin
      inflight = 0;
      for (int unsigned i = 0; i < NREG; i++) inflight += 32'(s_q[i].valid);
    end

    assign s_last = s_q[NREG-1];
  end

  // Last stage: clamp saturating multiplies; op[1] selects SAT, op[0] selects signed.
  always_comb begin
    res_last = s_last.data[WIDTH-1:0];
    sat_last = 1'b0;
    if (!s_last.op[MS_OP_SHIFT_BIT] && s_last.op[1]) begin
      if (!s_last.op[0] && sat_u_ovf(MS_PROD_W'(s_last.data), WIDTH)) begin
        res_last = '1;
        sat_last = 1'b1;
      end else if (s_last.op[0] && sat_s_ovf(MS_PROD_W'(s_last.data), WIDTH)) begin
        res_last = s_last.data[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        sat_last = 1'b1;
      end
    end
  end

  assign push     = s_last.valid & I_Active;
  assign pop      = fifo_valid & ~I_Nack & I_Active;
  assign fifo_din = {s_last.rls, sat_last, res_last};

  ms_out_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .cnt   (fifo_cnt)
  );

  assign O_Valid = fifo_valid;
  assign {O_Rls, O_Sat, O_Result} = fifo_dout;

endmodule
